// File: rtl/rr_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_arbiter_if
// Brief    : Request/acknowledge/grant bundle between bus masters, slave and
//            the round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_bus_arbiter_if #(
    parameter int N_MASTERS = 3
);
    localparam int ID_W = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] bus_req;
    logic                 bus_ack;
    logic [N_MASTERS-1:0] bus_grant;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic                 timeout_err;

    // The arbiter owns the grant side of the bundle
    modport master (
        input  bus_req,
        input  bus_ack,
        output bus_grant,
        output grant_valid,
        output grant_id,
        output timeout_err
    );

    modport slave (
        output bus_req,
        output bus_ack,
        input  bus_grant,
        input  grant_valid,
        input  grant_id,
        input  timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_arbiter
// Brief    : Round-robin bus arbiter holding each grant until bus_ack, with a
//            watchdog that revokes a grant the slave never acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
module rr_bus_arbiter #(
    parameter int N_MASTERS = 3,
    parameter int TIMEOUT   = 16
) (
    input  wire                   clk,
    input  wire                   reset_n,
    rr_bus_arbiter_if.master      bus
);
    localparam int ID_W  = $clog2(N_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [ID_W-1:0]  c_last_id = ID_W'(N_MASTERS - 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT - 1);
    localparam logic [N_MASTERS-1:0] c_one = {{(N_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t               r_state;
    logic [N_MASTERS-1:0] r_grant;
    logic                 r_grant_valid;
    logic [ID_W-1:0]      r_grant_id;
    logic                 r_timeout_err;
    logic [CNT_W-1:0]     r_cnt;
    logic [ID_W-1:0]      r_last_owner;

    logic [ID_W-1:0]      w_scan_base;
    logic [ID_W-1:0]      w_scan_idx;
    logic [ID_W-1:0]      w_pick_id;
    logic                 w_any_req;
    logic [N_MASTERS-1:0] w_pick_onehot;

    // On an ack handoff the current owner becomes last_owner in the same edge,
    // so the scan must already start after the granted master.
    assign w_scan_base = (r_state == S_BUSY) ? r_grant_id : r_last_owner;

    always_comb begin
        w_pick_id  = '0;
        w_any_req  = 1'b0;
        w_scan_idx = w_scan_base;
        for (int k = 0; k < N_MASTERS; k++) begin
            w_scan_idx = (w_scan_idx == c_last_id) ? '0 : w_scan_idx + ID_W'(1);
            if (!w_any_req && bus.bus_req[w_scan_idx]) begin
                w_pick_id = w_scan_idx;
                w_any_req = 1'b1;
            end
        end
    end

    assign w_pick_onehot = c_one << w_pick_id;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
            r_last_owner  <= c_last_id;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant       <= w_pick_onehot;
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_pick_id;
                        r_cnt         <= '0;
                        r_state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Ack takes priority over a simultaneous watchdog expiry
                    if (bus.bus_ack) begin
                        r_last_owner <= r_grant_id;
                        r_cnt        <= '0;
                        if (w_any_req) begin
                            r_grant       <= w_pick_onehot;
                            r_grant_valid <= 1'b1;
                            r_grant_id    <= w_pick_id;
                        end else begin
                            r_grant       <= '0;
                            r_grant_valid <= 1'b0;
                            r_grant_id    <= '0;
                            r_state       <= S_IDLE;
                        end
                    end else if (r_cnt == c_cnt_max) begin
                        r_last_owner  <= r_grant_id;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_grant_id    <= '0;
                        r_timeout_err <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= S_RECOVER;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RECOVER: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.bus_grant   = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout_err = r_timeout_err;
endmodule
`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_bus_arbiter
// Brief    : Directed, table-driven self-checking bench for rr_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_bus_arbiter;
    localparam int N   = 3;
    localparam int TMO = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    rr_bus_arbiter_if #(.N_MASTERS(N)) bus ();

    rr_bus_arbiter #(.N_MASTERS(N), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic       ack;
        logic [2:0] grant;
        logic [1:0] id;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [2:0] eg,
                         input logic [1:0] eid, input logic etmo);
        logic ev;
        ev = |eg;
        n_cmp++;
        if (bus.bus_grant !== eg || bus.grant_valid !== ev ||
            bus.grant_id !== eid || bus.timeout_err !== etmo) begin
            n_bad++;
            $display("FAIL %s: got grant=%b valid=%b id=%0d tmo=%b, need grant=%b valid=%b id=%0d tmo=%b",
                     name, bus.bus_grant, bus.grant_valid, bus.grant_id, bus.timeout_err,
                     eg, ev, eid, etmo);
        end
    endtask

    // Drive inputs, take one rising edge, settle just after it
    task automatic step(input logic [2:0] req, input logic ack);
        bus.bus_req = req;
        bus.bus_ack = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rotation with ack every 3rd cycle
        vecs[0]  = '{3'b111, 1'b0, 3'b001, 2'd0};
        vecs[1]  = '{3'b111, 1'b0, 3'b001, 2'd0};
        vecs[2]  = '{3'b111, 1'b0, 3'b001, 2'd0};
        vecs[3]  = '{3'b111, 1'b1, 3'b010, 2'd1};
        vecs[4]  = '{3'b111, 1'b0, 3'b010, 2'd1};
        vecs[5]  = '{3'b111, 1'b0, 3'b010, 2'd1};
        vecs[6]  = '{3'b111, 1'b1, 3'b100, 2'd2};
        vecs[7]  = '{3'b111, 1'b0, 3'b100, 2'd2};
        vecs[8]  = '{3'b111, 1'b0, 3'b100, 2'd2};
        vecs[9]  = '{3'b111, 1'b1, 3'b001, 2'd0};
        vecs[10] = '{3'b000, 1'b1, 3'b000, 2'd0};
        // lone requester re-granted back-to-back
        vecs[11] = '{3'b100, 1'b0, 3'b100, 2'd2};
        vecs[12] = '{3'b100, 1'b1, 3'b100, 2'd2};
        vecs[13] = '{3'b100, 1'b0, 3'b100, 2'd2};
        vecs[14] = '{3'b100, 1'b1, 3'b100, 2'd2};
        vecs[15] = '{3'b000, 1'b1, 3'b000, 2'd0};
        // grant held after request withdrawal until ack
        vecs[16] = '{3'b010, 1'b0, 3'b010, 2'd1};
        vecs[17] = '{3'b000, 1'b0, 3'b010, 2'd1};
        vecs[18] = '{3'b000, 1'b0, 3'b010, 2'd1};
        vecs[19] = '{3'b000, 1'b0, 3'b010, 2'd1};
        vecs[20] = '{3'b000, 1'b0, 3'b010, 2'd1};
        vecs[21] = '{3'b000, 1'b0, 3'b010, 2'd1};
        vecs[22] = '{3'b000, 1'b1, 3'b000, 2'd0};

        bus.bus_req = '0;
        bus.bus_ack = 1'b0;
        #12;
        check("reset_state", 3'b000, 2'd0, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].req, vecs[i].ack);
            check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].id, 1'b0);
        end

        // watchdog: last_owner=1, so a lone master 0 request wins
        step(3'b001, 1'b0);
        check("tmo_grant", 3'b001, 2'd0, 1'b0);
        for (int c = 1; c < TMO; c++) begin
            step(3'b011, 1'b0);
            check($sformatf("tmo_hold%0d", c), 3'b001, 2'd0, 1'b0);
        end
        step(3'b011, 1'b0);
        check("tmo_revoke", 3'b000, 2'd0, 1'b1);
        step(3'b011, 1'b1);
        check("tmo_recover", 3'b000, 2'd0, 1'b0);
        step(3'b011, 1'b0);
        check("tmo_regrant", 3'b010, 2'd1, 1'b0);

        // ack on the watchdog's final cycle wins
        for (int c = 1; c < TMO; c++) begin
            step(3'b011, 1'b0);
            check($sformatf("ackedge_hold%0d", c), 3'b010, 2'd1, 1'b0);
        end
        step(3'b011, 1'b1);
        check("ackedge_handoff", 3'b001, 2'd0, 1'b0);
        step(3'b011, 1'b0);
        check("ackedge_no_tmo", 3'b001, 2'd0, 1'b0);

        // asynchronous reset mid-tenure
        step(3'b011, 1'b1);
        check("pre_reset_grant", 3'b010, 2'd1, 1'b0);
        bus.bus_req = 3'b111;
        bus.bus_ack = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset", 3'b000, 2'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("reset_held", 3'b000, 2'd0, 1'b0);
        reset_n = 1'b1;
        step(3'b111, 1'b0);
        check("post_reset_grant", 3'b001, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
